// File: rtl/adc_sar_mc_ctrl_if.sv
`default_nettype none
// ============================================================================
// adc_sar_mc_ctrl_if : register-side and analog-core signals of the SAR controller
// Revision: 1.0
// ============================================================================
interface adc_sar_mc_ctrl_if #(
  parameter int RES      = 12,
  parameter int CHANNELS = 4,
  parameter int RESULT_W = 16
);
  localparam int CW = $clog2(CHANNELS);

  logic                start_conversion_in;
  logic [CHANNELS-1:0] channel_mask_in;
  logic [3:0]          osr_log2_in;
  logic                continuous_in;
  logic                comparator_in;
  logic                sample_out;
  logic [RES-1:0]      dac_code_out;
  logic [CW-1:0]       chan_sel_out;
  logic [RESULT_W-1:0] result_out;
  logic [CW-1:0]       result_channel_out;
  logic                conversion_finished_out;
  logic                conversion_finished_osr_out;
  logic                busy_out;

  // master is the controller; slave is the register block plus analog core
  modport master (
    input  start_conversion_in, channel_mask_in, osr_log2_in, continuous_in, comparator_in,
    output sample_out, dac_code_out, chan_sel_out, result_out, result_channel_out,
           conversion_finished_out, conversion_finished_osr_out, busy_out
  );
  modport slave (
    output start_conversion_in, channel_mask_in, osr_log2_in, continuous_in, comparator_in,
    input  sample_out, dac_code_out, chan_sel_out, result_out, result_channel_out,
           conversion_finished_out, conversion_finished_osr_out, busy_out
  );
endinterface
`default_nettype wire

// File: rtl/adc_sar_mc_ctrl.sv
`default_nettype none
// ============================================================================
// adc_sar_mc_ctrl : multi-channel SAR ADC controller with per-channel oversampling
// Revision: 1.0
// ============================================================================
module adc_sar_mc_ctrl #(
  parameter int RES           = 12,
  parameter int CHANNELS      = 4,
  parameter int OSR_MAX_LOG2  = 4,
  parameter int RESULT_W      = 16,
  parameter int SAMPLE_CYCLES = 2
) (
  input  logic              clk_dig,
  input  logic              rst,
  adc_sar_mc_ctrl_if.master bus
);
  localparam int CW    = $clog2(CHANNELS);
  localparam int ACC_W = RES + OSR_MAX_LOG2;
  localparam int SW    = (ACC_W > RESULT_W) ? ACC_W : RESULT_W;
  localparam int CNT_W = OSR_MAX_LOG2 + 1;
  localparam int SMP_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int STP_W = $clog2(RES);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SAMPLE  = 2'd1;
  localparam logic [1:0] S_CONVERT = 2'd2;
  localparam logic [1:0] S_ACCUM   = 2'd3;

  localparam logic [RES-1:0] MSB_TRIAL = {1'b1, {(RES-1){1'b0}}};
  localparam logic [3:0]     OSR_CLAMP = 4'(OSR_MAX_LOG2);

  // {found, index} of the lowest set mask bit strictly above 'above'
  function automatic logic [CW:0] pick_chan(input logic [CHANNELS-1:0] mask, input int above);
    logic [CW:0] r;
    r = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (mask[i] && (i > above)) r = {1'b1, CW'(i)};
    end
    return r;
  endfunction

  logic [1:0]          state_q, state_d;
  logic [SMP_W-1:0]    smp_q, smp_d;
  logic [STP_W-1:0]    step_q, step_d;
  logic [RES-1:0]      code_q, code_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    ocnt_q, ocnt_d;
  logic [CHANNELS-1:0] mask_q, mask_d;
  logic [3:0]          osr_q, osr_d;
  logic [CW-1:0]       chan_q, chan_d;
  logic [RESULT_W-1:0] result_q, result_d;
  logic [CW-1:0]       rchan_q, rchan_d;
  logic                fin_q, fin_d;
  logic                fin_osr_q, fin_osr_d;
  logic                sample_q, sample_d;
  logic                busy_q, busy_d;

  logic [RES-1:0]      trial;
  logic [RES-1:0]      final_code;
  logic [ACC_W-1:0]    sum;
  logic [RESULT_W-1:0] sat;
  logic [3:0]          osr_in_clamped;
  logic                osr_last;
  logic [CW:0]         first_in;
  logic [CW:0]         next_hi;

  assign osr_in_clamped = (bus.osr_log2_in > OSR_CLAMP) ? OSR_CLAMP : bus.osr_log2_in;
  assign osr_last       = (ocnt_q == CNT_W'((32'd1 << osr_q) - 32'd1));
  assign first_in       = pick_chan(bus.channel_mask_in, -1);
  assign next_hi        = pick_chan(mask_q, int'(chan_q));

  // Current trial bit keeps the comparator decision, next lower bit becomes the new trial
  assign trial      = MSB_TRIAL >> step_q;
  assign final_code = (bus.comparator_in ? code_q : (code_q & ~trial)) | (trial >> 1);
  assign sum        = acc_q + ACC_W'(final_code);
  assign sat        = (SW'(sum) > SW'({RESULT_W{1'b1}})) ? {RESULT_W{1'b1}} : RESULT_W'(SW'(sum));

  always_comb begin
    state_d   = state_q;
    smp_d     = smp_q;
    step_d    = step_q;
    code_d    = code_q;
    acc_d     = acc_q;
    ocnt_d    = ocnt_q;
    mask_d    = mask_q;
    osr_d     = osr_q;
    chan_d    = chan_q;
    result_d  = result_q;
    rchan_d   = rchan_q;
    fin_d     = 1'b0;
    fin_osr_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start_conversion_in && (|bus.channel_mask_in)) begin
          state_d = S_SAMPLE;
          mask_d  = bus.channel_mask_in;
          osr_d   = osr_in_clamped;
          acc_d   = '0;
          ocnt_d  = '0;
          smp_d   = '0;
          code_d  = '0;
          chan_d  = first_in[CW-1:0];
        end
      end
      S_SAMPLE: begin
        if (smp_q == SMP_W'(SAMPLE_CYCLES - 1)) begin
          state_d = S_CONVERT;
          step_d  = '0;
          code_d  = MSB_TRIAL;
        end else begin
          smp_d = smp_q + 1'b1;
        end
      end
      S_CONVERT: begin
        code_d = final_code;
        if (step_q == STP_W'(RES - 1)) begin
          // Pulses and result are registered here so they appear in the ACCUM cycle
          state_d = S_ACCUM;
          fin_d   = 1'b1;
          if (osr_last) begin
            acc_d     = '0;
            result_d  = sat;
            rchan_d   = chan_q;
            fin_osr_d = 1'b1;
          end else begin
            acc_d = sum;
          end
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      S_ACCUM: begin
        state_d = S_SAMPLE;
        smp_d   = '0;
        code_d  = '0;
        if (!osr_last) begin
          ocnt_d = ocnt_q + 1'b1;
        end else begin
          ocnt_d = '0;
          if (next_hi[CW]) begin
            chan_d = next_hi[CW-1:0];
          end else if (bus.continuous_in && (|bus.channel_mask_in)) begin
            mask_d = bus.channel_mask_in;
            osr_d  = osr_in_clamped;
            chan_d = first_in[CW-1:0];
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    sample_d = (state_d == S_SAMPLE);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_dig or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      smp_q     <= '0;
      step_q    <= '0;
      code_q    <= '0;
      acc_q     <= '0;
      ocnt_q    <= '0;
      mask_q    <= '0;
      osr_q     <= '0;
      chan_q    <= '0;
      result_q  <= '0;
      rchan_q   <= '0;
      fin_q     <= 1'b0;
      fin_osr_q <= 1'b0;
      sample_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      smp_q     <= smp_d;
      step_q    <= step_d;
      code_q    <= code_d;
      acc_q     <= acc_d;
      ocnt_q    <= ocnt_d;
      mask_q    <= mask_d;
      osr_q     <= osr_d;
      chan_q    <= chan_d;
      result_q  <= result_d;
      rchan_q   <= rchan_d;
      fin_q     <= fin_d;
      fin_osr_q <= fin_osr_d;
      sample_q  <= sample_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.sample_out                  = sample_q;
  assign bus.dac_code_out                = code_q;
  assign bus.chan_sel_out                = chan_q;
  assign bus.result_out                  = result_q;
  assign bus.result_channel_out          = rchan_q;
  assign bus.conversion_finished_out     = fin_q;
  assign bus.conversion_finished_osr_out = fin_osr_q;
  assign bus.busy_out                    = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_adc_sar_mc_ctrl.sv
`default_nettype none
// ============================================================================
// tb_adc_sar_mc_ctrl : directed bench for the multi-channel SAR controller
// Revision: 1.0
// ============================================================================
module tb_adc_sar_mc_ctrl;
  logic clk_dig = 1'b0;
  logic rst     = 1'b1;
  always #5 clk_dig = ~clk_dig;

  adc_sar_mc_ctrl_if #(.RES(12), .CHANNELS(4), .RESULT_W(16)) ifa ();
  adc_sar_mc_ctrl_if #(.RES(12), .CHANNELS(4), .RESULT_W(12)) ifb ();

  adc_sar_mc_ctrl #(.RES(12), .CHANNELS(4), .OSR_MAX_LOG2(4), .RESULT_W(16), .SAMPLE_CYCLES(2))
    u_dut_a (.clk_dig(clk_dig), .rst(rst), .bus(ifa));
  adc_sar_mc_ctrl #(.RES(12), .CHANNELS(4), .OSR_MAX_LOG2(4), .RESULT_W(12), .SAMPLE_CYCLES(2))
    u_dut_b (.clk_dig(clk_dig), .rst(rst), .bus(ifb));

  // Ideal analog comparator: input at or above the DAC code reads as 1
  logic [11:0] vin_a [4];
  logic [11:0] vin_b;
  assign ifa.comparator_in = (vin_a[ifa.chan_sel_out] >= ifa.dac_code_out);
  assign ifb.comparator_in = (vin_b >= ifb.dac_code_out);

  int n_chk  = 0;
  int n_fail = 0;
  int n_fin  = 0;
  int n_osr  = 0;
  int cyc_cnt = 0;
  logic [17:0] res_q[$];
  int          stamp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_dig) begin
    cyc_cnt++;
    if (ifa.conversion_finished_out) n_fin++;
    if (ifa.conversion_finished_osr_out) begin
      n_osr++;
      res_q.push_back({ifa.result_channel_out, ifa.result_out});
      stamp_q.push_back(cyc_cnt);
    end
  end

  task automatic clear_mon();
    n_fin = 0;
    n_osr = 0;
    res_q.delete();
    stamp_q.delete();
  endtask

  // Start a scan on DUT A and return the number of busy cycles
  task automatic run_scan(input int max_cyc, output int busy_cyc);
    int c;
    ifa.start_conversion_in = 1'b1;
    @(posedge clk_dig);
    @(negedge clk_dig);
    ifa.start_conversion_in = 1'b0;
    c = 1;
    while (ifa.busy_out && c < max_cyc) begin
      @(negedge clk_dig);
      c++;
    end
    chk("scan_done", {31'd0, ifa.busy_out}, 32'd0);
    busy_cyc = c - 1;
  endtask

  logic [11:0] exp_tr [4];
  logic [11:0] got_tr [4];
  int bc;
  int nb_fin, nb_osr;
  logic [11:0] res_b;

  initial begin
    exp_tr = '{12'h800, 12'h400, 12'h600, 12'h500};
    vin_a  = '{12'h000, 12'h000, 12'h000, 12'h000};
    vin_b  = 12'hFFF;
    ifa.start_conversion_in = 1'b0; ifa.channel_mask_in = 4'b0001;
    ifa.osr_log2_in = 4'd0;         ifa.continuous_in = 1'b0;
    ifb.start_conversion_in = 1'b0; ifb.channel_mask_in = 4'b0001;
    ifb.osr_log2_in = 4'd1;         ifb.continuous_in = 1'b0;
    repeat (3) @(negedge clk_dig);
    rst = 1'b0;
    @(negedge clk_dig);

    chk("rst_sample", {31'd0, ifa.sample_out}, 32'd0);
    chk("rst_dac", {20'd0, ifa.dac_code_out}, 32'd0);
    chk("rst_chan", {30'd0, ifa.chan_sel_out}, 32'd0);
    chk("rst_result", {16'd0, ifa.result_out}, 32'd0);
    chk("rst_rchan", {30'd0, ifa.result_channel_out}, 32'd0);
    chk("rst_pulses", {30'd0, ifa.conversion_finished_out, ifa.conversion_finished_osr_out}, 32'd0);
    chk("rst_busy", {31'd0, ifa.busy_out}, 32'd0);

    // Single conversion, cycle-accurate
    vin_a[0] = 12'h5A5;
    clear_mon();
    ifa.start_conversion_in = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk_dig);
      @(negedge clk_dig);
      if (c == 1) begin
        ifa.start_conversion_in = 1'b0;
        chk("t1_busy_c1", {31'd0, ifa.busy_out}, 32'd1);
        chk("t1_sample_c1", {31'd0, ifa.sample_out}, 32'd1);
      end
      if (c >= 3 && c <= 6) got_tr[c-3] = ifa.dac_code_out;
      if (c == 14) chk("t1_fin_early", {31'd0, ifa.conversion_finished_out}, 32'd0);
      if (c == 15) begin
        chk("t1_fin", {31'd0, ifa.conversion_finished_out}, 32'd1);
        chk("t1_fin_osr", {31'd0, ifa.conversion_finished_osr_out}, 32'd1);
        chk("t1_result", {16'd0, ifa.result_out}, 32'h5A5);
        chk("t1_rchan", {30'd0, ifa.result_channel_out}, 32'd0);
      end
      if (c == 16) chk("t1_idle", {31'd0, ifa.busy_out}, 32'd0);
    end
    for (int i = 0; i < 4; i++) chk($sformatf("t1_trial%0d", i), {20'd0, got_tr[i]}, {20'd0, exp_tr[i]});

    // Oversampling 2^4 with constant input
    vin_a[0] = 12'd100;
    ifa.osr_log2_in = 4'd4;
    clear_mon();
    run_scan(400, bc);
    chk("t2_fin_cnt", n_fin, 32'd16);
    chk("t2_osr_cnt", n_osr, 32'd1);
    chk("t2_cycles", bc, 32'd240);
    chk("t2_result", {16'd0, ifa.result_out}, 32'd1600);

    // Exponent above the maximum clamps to 4
    vin_a[0] = 12'd3;
    ifa.osr_log2_in = 4'd9;
    clear_mon();
    run_scan(400, bc);
    chk("t2c_fin_cnt", n_fin, 32'd16);
    chk("t2c_result", {16'd0, ifa.result_out}, 32'd48);

    // Two-channel scan
    vin_a[1] = 12'h123;
    vin_a[3] = 12'hFFF;
    ifa.osr_log2_in = 4'd0;
    ifa.channel_mask_in = 4'b1010;
    clear_mon();
    run_scan(100, bc);
    chk("t3_osr_cnt", n_osr, 32'd2);
    chk("t3_cycles", bc, 32'd30);
    if (res_q.size() >= 2) begin
      chk("t3_res0", {14'd0, res_q[0]}, {14'd0, 2'd1, 16'h0123});
      chk("t3_res1", {14'd0, res_q[1]}, {14'd0, 2'd3, 16'h0FFF});
    end

    // Continuous rescans of channel 2, then drop continuous mid-conversion
    vin_a[2] = 12'h03C;
    ifa.channel_mask_in = 4'b0100;
    ifa.continuous_in = 1'b1;
    clear_mon();
    ifa.start_conversion_in = 1'b1;
    @(posedge clk_dig);
    @(negedge clk_dig);
    ifa.start_conversion_in = 1'b0;
    for (int i = 0; i < 100 && n_osr < 3; i++) @(negedge clk_dig);
    repeat (5) @(negedge clk_dig);
    chk("t5_busy_mid", {31'd0, ifa.busy_out}, 32'd1);
    ifa.continuous_in = 1'b0;
    for (int i = 0; i < 60 && ifa.busy_out; i++) @(negedge clk_dig);
    chk("t5_idle", {31'd0, ifa.busy_out}, 32'd0);
    chk("t5_osr_cnt", n_osr, 32'd4);
    if (stamp_q.size() >= 2) chk("t5_period", stamp_q[1] - stamp_q[0], 32'd15);
    foreach (res_q[i]) chk($sformatf("t5_res%0d", i), {14'd0, res_q[i]}, {14'd0, 2'd2, 16'h003C});

    // Start with an empty mask stays idle
    ifa.channel_mask_in = 4'b0000;
    ifa.start_conversion_in = 1'b1;
    repeat (5) @(negedge clk_dig);
    chk("t6_busy", {31'd0, ifa.busy_out}, 32'd0);
    chk("t6_sample", {31'd0, ifa.sample_out}, 32'd0);
    ifa.start_conversion_in = 1'b0;

    // Saturation on the narrow-result instance
    nb_fin = 0;
    nb_osr = 0;
    res_b  = '0;
    ifb.start_conversion_in = 1'b1;
    @(posedge clk_dig);
    @(negedge clk_dig);
    ifb.start_conversion_in = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (ifb.conversion_finished_out) nb_fin++;
      if (ifb.conversion_finished_osr_out) begin
        nb_osr++;
        res_b = ifb.result_out;
      end
      if (!ifb.busy_out) break;
      @(negedge clk_dig);
    end
    chk("t7_busy", {31'd0, ifb.busy_out}, 32'd0);
    chk("t7_fin_cnt", nb_fin, 32'd2);
    chk("t7_osr_cnt", nb_osr, 32'd1);
    chk("t7_result", {20'd0, res_b}, 32'hFFF);

    // Asynchronous reset during CONVERT
    vin_a[2] = 12'h2B7;
    ifa.channel_mask_in = 4'b0100;
    clear_mon();
    ifa.start_conversion_in = 1'b1;
    @(posedge clk_dig);
    @(negedge clk_dig);
    ifa.start_conversion_in = 1'b0;
    repeat (5) @(negedge clk_dig);
    chk("t8_pre_chan", {30'd0, ifa.chan_sel_out}, 32'd2);
    rst = 1'b1;
    #1;
    chk("t8_sample", {31'd0, ifa.sample_out}, 32'd0);
    chk("t8_dac", {20'd0, ifa.dac_code_out}, 32'd0);
    chk("t8_chan", {30'd0, ifa.chan_sel_out}, 32'd0);
    chk("t8_result", {16'd0, ifa.result_out}, 32'd0);
    chk("t8_rchan", {30'd0, ifa.result_channel_out}, 32'd0);
    chk("t8_busy", {31'd0, ifa.busy_out}, 32'd0);
    @(posedge clk_dig);
    @(negedge clk_dig);
    rst = 1'b0;
    @(negedge clk_dig);
    chk("t8_no_pulse", n_fin + n_osr, 32'd0);
    run_scan(100, bc);
    chk("t8_cycles", bc, 32'd15);
    chk("t8_rerun", {16'd0, ifa.result_out}, 32'h2B7);
    chk("t8_rerun_ch", {30'd0, ifa.result_channel_out}, 32'd2);
    chk("t8_fin_cnt", n_fin, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
